// File: rtl/rns_seq_pkg.sv
// Shared definitions for the RNS operation sequencer: op codes, FSM states
// and a helper that tells whether an op needs a residue unit.
package rns_seq_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_ADD  = 2'b00;
  localparam op_t OP_SUB  = 2'b01;
  localparam op_t OP_MUL  = 2'b10;
  localparam op_t OP_ZERO = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Zero is answered locally; every other op is routed through the demux.
  function automatic logic op_uses_unit(input op_t op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL: op_uses_unit = 1'b1;
      default:                op_uses_unit = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: the requester that did not win last time is
// preferred, otherwise whichever one is valid. Grant is one-hot or zero.
module rr_arbiter_2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant
);

  always_comb begin
    // NOTE: default first so no path through this block leaves grant unassigned (no latch).
    grant = 2'b00;
    if (enable) begin
      if (valid0 && (last_grant || !valid1)) begin
        grant = 2'b01;
      end else if (valid1) begin
        grant = 2'b10;
      end
    end
  end

endmodule

// File: rtl/rns_op_sequencer.sv
// Round-robin sequencer sharing the RNS demux/ALU between two requesters.
// Define SEQ_TIMEOUT_EN to add a watchdog on the WAIT state (reports rsp_err).
module rns_op_sequencer
  import rns_seq_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  output logic [WIDTH-1:0] dmx_a,
  output logic             dmx_sel0,
  output logic             dmx_sel1,
  input  logic             unit_done,
  input  logic [WIDTH-1:0] unit_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err
);

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("rns_op_sequencer: TIMEOUT must be at least 1");
  end

  state_t           state_q, state_d;
  logic [1:0]       grant;
  logic             arb_enable;
  logic             accept;
  logic             grant_id;
  logic             last_grant;
  op_t              op_sel, op_q;
  logic [WIDTH-1:0] a_sel, a_q;
  logic             id_q;
  logic [WIDTH-1:0] data_q;
  logic             expire;

  // Readiness is only offered in IDLE and never while reset is held.
  assign arb_enable = (state_q == S_IDLE) && !rst;

  rr_arbiter_2 u_arb (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant),
    .enable     (arb_enable),
    .grant      (grant)
  );

  assign accept   = |grant;
  assign grant_id = grant[1];
  assign op_sel   = grant_id ? req1_op : req0_op;
  assign a_sel    = grant_id ? req1_a  : req0_a;

`ifdef SEQ_TIMEOUT_EN
  localparam int               CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] wd_cnt;
  logic             err_q;

  // A done strobe in the expiry cycle takes priority over the watchdog.
  assign expire = (state_q == S_WAIT) && !unit_done && (wd_cnt == WD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (state_q == S_ISSUE) begin
      wd_cnt <= '0;
    end else if ((state_q == S_WAIT) && !unit_done) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (expire) begin
      err_q <= 1'b1;
    end
  end

  assign rsp_err = err_q;
`else
  assign expire  = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = op_uses_unit(op_sel) ? S_ISSUE : S_RESP;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (unit_done || expire) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Latched request and response payload; a done seen during ISSUE is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      op_q       <= OP_ADD;
      a_q        <= '0;
      id_q       <= 1'b0;
      data_q     <= '0;
    end else if (accept) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      last_grant <= grant_id;
      op_q       <= op_sel;
      a_q        <= a_sel;
      id_q       <= grant_id;
      if (!op_uses_unit(op_sel)) begin
        data_q <= '0;
      end
    end else if (state_q == S_WAIT) begin
      if (unit_done) begin
        data_q <= unit_result;
      end else if (expire) begin
        data_q <= '0;
      end
    end
  end

  always_comb begin
    req0_ready = grant[0];
    req1_ready = grant[1];
    dmx_a      = '0;
    dmx_sel0   = 1'b0;
    dmx_sel1   = 1'b0;
    rsp_valid  = 1'b0;
    case (state_q)
      S_ISSUE, S_WAIT: begin
        dmx_a    = a_q;
        dmx_sel0 = op_q[0];
        dmx_sel1 = op_q[1];
      end
      S_RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign rsp_id   = id_q;
  assign rsp_data = data_q;

endmodule

// File: tb/tb_rns_op_sequencer.sv
// Self-checking bench for rns_op_sequencer: directed cases plus random
// transactions checked against a transaction-level fairness/latency model.
module tb_rns_op_sequencer;

  localparam int WIDTH   = 4;
  localparam int TIMEOUT = 15;

  logic             clk;
  logic             rst;
  logic             req0_valid, req0_ready;
  logic [1:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic             req1_valid, req1_ready;
  logic [1:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] dmx_a;
  logic             dmx_sel0, dmx_sel1;
  logic             unit_done;
  logic [WIDTH-1:0] unit_result;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [WIDTH-1:0] rsp_data;

  int n_checks = 0;
  int n_pass   = 0;
  int m_last   = 1;  // model: requester that won the previous grant

  rns_op_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_op     (req0_op),
    .req0_a      (req0_a),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_op     (req1_op),
    .req1_a      (req1_a),
    .dmx_a       (dmx_a),
    .dmx_sel0    (dmx_sel0),
    .dmx_sel1    (dmx_sel1),
    .unit_done   (unit_done),
    .unit_result (unit_result),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: got simulation still running, expected finish");
    $fatal(1, "bench time limit exceeded");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready0"}, req0_ready, 0);
    check({tag, "_ready1"}, req1_ready, 0);
    check({tag, "_dmx_a"}, dmx_a, 0);
    check({tag, "_sel"}, {dmx_sel1, dmx_sel0}, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_id"}, rsp_id, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
  endtask

  // One full transaction: offer requests in IDLE, play the unit, then drain
  // the response with `stall` cycles of backpressure. Requests stay asserted
  // throughout so any premature second accept is visible.
  task automatic run_txn(input bit v0, input bit v1,
                         input logic [1:0] op0, input logic [1:0] op1,
                         input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] a1,
                         input int delay, input bit early,
                         input logic [WIDTH-1:0] result, input int stall);
    int               g;
    logic [1:0]       op;
    logic [WIDTH-1:0] a, exp_data;
    req0_valid = v0; req0_op = op0; req0_a = a0;
    req1_valid = v1; req1_op = op1; req1_a = a1;
    rsp_ready = 1'b0; unit_done = 1'b0; unit_result = '0;
    #1;
    check("idle_rsp_valid", rsp_valid, 0);
    check("idle_dmx_a", dmx_a, 0);
    if (!v0 && !v1) begin
      check("idle_none_ready", {req1_ready, req0_ready}, 0);
      tick();
      return;
    end
    g = (v0 && v1) ? ((m_last == 1) ? 0 : 1) : (v0 ? 0 : 1);
    check("grant_ready0", req0_ready, (g == 0));
    check("grant_ready1", req1_ready, (g == 1));
    op = (g == 1) ? op1 : op0;
    a  = (g == 1) ? a1  : a0;
    m_last = g;
    tick();
    if (op == 2'b11) begin
      exp_data = '0;
    end else begin
      unit_done = early; unit_result = ~result;
      #1;
      check("issue_dmx_a", dmx_a, a);
      check("issue_sel", {dmx_sel1, dmx_sel0}, op);
      check("issue_ready", {req1_ready, req0_ready}, 0);
      check("issue_rsp_valid", rsp_valid, 0);
      tick();
      unit_done = 1'b0;
      for (int i = 0; i < delay; i++) begin
        #1;
        check("wait_dmx_a", dmx_a, a);
        check("wait_sel", {dmx_sel1, dmx_sel0}, op);
        check("wait_rsp_valid", rsp_valid, 0);
        tick();
      end
      unit_done = 1'b1; unit_result = result;
      #1;
      check("done_dmx_a", dmx_a, a);
      tick();
      unit_done = 1'b0; unit_result = '0;
      exp_data = result;
    end
    for (int i = 0; i <= stall; i++) begin
      rsp_ready = (i == stall);
      #1;
      check("resp_valid", rsp_valid, 1);
      check("resp_id", rsp_id, g);
      check("resp_data", rsp_data, exp_data);
      check("resp_err", rsp_err, 0);
      check("resp_dmx", {dmx_a, dmx_sel1, dmx_sel0}, 0);
      check("resp_ready", {req1_ready, req0_ready}, 0);
      tick();
    end
    rsp_ready = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check_all_zero("reset");
    tick();
    tick();
    rst = 1'b0;
    m_last = 1;
    #1;
    check_all_zero("post_reset");
  endtask

`ifdef SEQ_TIMEOUT_EN
  // Mul with no done: expiry after TIMEOUT WAIT cycles; optionally a done in
  // the final WAIT cycle, which must win over the watchdog.
  task automatic run_timeout(input bit late_done, input logic [WIDTH-1:0] result);
    req0_valid = 1'b1; req0_op = 2'b10; req0_a = 4'h9;
    req1_valid = 1'b0; rsp_ready = 1'b0; unit_done = 1'b0;
    #1;
    check("to_accept", req0_ready, (m_last == 1));
    m_last = 0;
    tick();
    tick();
    for (int i = 0; i < TIMEOUT; i++) begin
      unit_done = late_done && (i == TIMEOUT - 1);
      unit_result = result;
      #1;
      check("to_wait_rsp_valid", rsp_valid, 0);
      tick();
    end
    unit_done = 1'b0;
    rsp_ready = 1'b1;
    #1;
    check("to_rsp_valid", rsp_valid, 1);
    check("to_rsp_err", rsp_err, !late_done);
    check("to_rsp_data", rsp_data, late_done ? result : 0);
    tick();
    rsp_ready = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0;
    unit_done = 1'b0; unit_result = '0; rsp_ready = 1'b0;
    #2;
    apply_reset();

    // First simultaneous request goes to requester 0.
    run_txn(1, 1, 2'b00, 2'b00, 4'h1, 4'h2, 1, 0, 4'h3, 0);
    // Single sub: done in the first WAIT cycle.
    run_txn(1, 0, 2'b01, 2'b00, 4'h7, 4'h0, 0, 0, 4'h3, 0);
    // Fairness: four adds with both valid.
    for (int i = 0; i < 4; i++)
      run_txn(1, 1, 2'b00, 2'b00, 4'(i), 4'(i + 8), 0, 0, 4'(i + 4), 0);
    // Zero op from requester 1.
    run_txn(0, 1, 2'b00, 2'b11, 4'h0, 4'hF, 0, 0, 4'h0, 0);
    // Backpressure with a competing request; early done in ISSUE ignored.
    run_txn(1, 1, 2'b00, 2'b10, 4'h5, 4'h6, 2, 1, 4'hA, 5);

    for (int n = 0; n < 60; n++) begin
      run_txn(($urandom % 4) != 0, ($urandom % 4) != 0,
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              4'($urandom), 4'($urandom),
              $urandom_range(0, 4), 1'($urandom % 2), 4'($urandom),
              $urandom_range(0, 3));
    end

    // Reset mid-WAIT: no response may appear afterwards.
    req0_valid = 1'b1; req0_op = 2'b10; req0_a = 4'h5;
    req1_valid = 1'b0; rsp_ready = 1'b0;
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    tick();
    apply_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("no_rsp_after_reset", rsp_valid, 0);
      check("dmx_idle_after_reset", dmx_a, 0);
      tick();
    end
    rsp_ready = 1'b0;
    run_txn(1, 1, 2'b01, 2'b01, 4'h2, 4'h3, 1, 0, 4'hC, 1);

`ifdef SEQ_TIMEOUT_EN
    run_timeout(1'b0, 4'h0);
    run_timeout(1'b1, 4'h6);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rns_op_sequencer.md
Name: rns_op_sequencer

Overview:
- Shares the single operand-routing demux and its add/sub/mul/zero residue units between two requesters.
- Arbitrates round-robin, latches the winning request and drives the operand and select lines.
- Waits for the unit's done strobe, then returns a tagged response over a valid/ready handshake.
- Sits between the requester front-ends and the demux/ALU datapath; one operation in flight at a time.

Parameters:
- WIDTH, 4, residue operand/result width in bits
- TIMEOUT, 15, watchdog limit in cycles spent in WAIT (used only with SEQ_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 accepted this cycle
- req0_op  in  2  00 add, 01 sub, 10 mul, 11 zero
- req0_a  in  WIDTH  requester 0 operand
- req1_valid / req1_ready / req1_op / req1_a  same as requester 0, for requester 1
- dmx_a  out  WIDTH  operand to demux
- dmx_sel0  out  1  demux select0 (= op[0])
- dmx_sel1  out  1  demux select1 (= op[1])
- unit_done  in  1  selected unit result valid, single-cycle strobe
- unit_result  in  WIDTH  selected unit result
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester index of response
- rsp_data  out  WIDTH  result
- rsp_err  out  1  watchdog expiry flag

Behaviour:
- Reset (async, rst=1) forces:
  - state IDLE, last_grant=1 (requester 0 wins first), watchdog count 0.
  - All outputs 0: reqN_ready, dmx_a, dmx_sel0, dmx_sel1, rsp_valid, rsp_id, rsp_data, rsp_err.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - grant = the requester not equal to last_grant if it is valid, else the other one if valid.
  - reqN_ready = 1 combinationally for the granted requester only, and only in IDLE.
  - On accept: latch op, a and id; set last_grant=id.
  - op 11 goes to RESP with rsp_data=0. Any other op goes to ISSUE.
- ISSUE (1 cycle): drive dmx_a=latched a, dmx_sel1:dmx_sel0=op; next state WAIT.
- WAIT:
  - Hold dmx_a and dmx_sel* stable.
  - On unit_done: capture unit_result into rsp_data, go to RESP.
  - A unit_done arriving in ISSUE is ignored.
- RESP:
  - rsp_valid=1; rsp_id, rsp_data and rsp_err held stable until rsp_valid && rsp_ready.
  - Then go to IDLE; dmx_a returns to 0, which blanks all demux outputs.
- Outside ISSUE/WAIT: dmx_a=0 and dmx_sel*=0.
- Minimum latency, non-zero op: accept (cycle 0) -> ISSUE (1) -> WAIT (2) -> rsp_valid at cycle 3 if done arrives in cycle 2.
- Minimum latency, zero op: rsp_valid at cycle 1.
- Back-to-back: no new accept until RESP completes; reqN_ready=0 in ISSUE/WAIT/RESP.
- A request dropping valid before accept is not remembered.
- Both requesters valid continuously: grants strictly alternate 0,1,0,1.
- rst asserted mid-operation: in-flight operation discarded, no response produced.

Optional Feature:
- Macro: SEQ_TIMEOUT_EN.
- Defined:
  - A counter increments each cycle in WAIT and clears on entry to WAIT.
  - When it reaches TIMEOUT without unit_done, go to RESP with rsp_err=1 and rsp_data=0.
  - unit_done in the same cycle as expiry wins (normal response, rsp_err=0).
- Undefined: no counter logic; WAIT lasts indefinitely; rsp_err tied 0.

Decomposition:
- Package rns_seq_pkg holds:
  - op code constants OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_ZERO=2'b11
  - state encodings for IDLE/ISSUE/WAIT/RESP
- Sub-module rr_arbiter_2 (inputs: two valids, last_grant, enable; outputs: grant one-hot) is natural and separately testable.

Test Plan:
- Reset: after rst pulse, all outputs 0, state IDLE; first simultaneous request from both -> req0_ready=1.
- Single sub: req0 op=01 a=4'h7, unit_done with result 4'h3 two cycles later -> dmx_sel0=1, dmx_sel1=0, dmx_a=7 during WAIT; then rsp_valid, rsp_id=0, rsp_data=3.
- Fairness: both valid for 4 operations, all ops add -> rsp_id sequence 0,1,0,1.
- Zero op: req1 op=11 a=4'hF -> rsp_valid next cycle, rsp_data=0, rsp_id=1, dmx_a stays 0.
- Backpressure: hold rsp_ready=0 for 5 cycles with req0 still valid -> rsp fields stable, req0_ready=0, no second accept until the handshake completes.
- SEQ_TIMEOUT_EN with TIMEOUT=15: mul issued, unit_done never asserted -> rsp_valid with rsp_err=1, rsp_data=0 after 15 WAIT cycles. Reset mid-WAIT -> no response.
